// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-share sequencer: op codes, default widths
// and the sequencer state encoding.
package alu_share_pkg;
  localparam int OP_W_DEF = 2;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;
endpackage

// File: rtl/alu_share_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the last served index + 1.
// The pointer only advances when the owner of a grant completes.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          upd_en,
  output logic [N-1:0]  grant
);
  logic [IW-1:0] r_last;

  // Pointer resets to N-1 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last <= IW'(N - 1);
    else if (upd_en) r_last <= last_grant;
  end

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(r_last) + 1 + k) % N;
      if (req[idx] && !found) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_share_sequencer.sv
// Initiator for the shared combinational ALU: grants one requester at a time,
// holds its operands on the ALU inputs, captures the result and returns it.
module alu_share_sequencer
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int OP_W    = OP_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [OP_W-1:0]           alu_op_code,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              r_state, w_next;
  logic [IW-1:0]       r_gidx, w_gidx;
  logic [NUM_REQ-1:0]  w_grant, w_gidx_oh, r_rsp_valid;
  logic                w_req_hs, w_rsp_hs;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a, r_b, r_rsp_data;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_valid),
    .last_grant (r_gidx),
    .upd_en     (w_rsp_hs),
    .grant      (w_grant)
  );

  always_comb begin
    req_ready = (r_state == IDLE) ? w_grant : '0;
    w_req_hs  = |(req_valid & req_ready);
    w_gidx    = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) w_gidx = IW'(i);
    for (int i = 0; i < NUM_REQ; i++)
      w_gidx_oh[i] = (r_gidx == IW'(i));
    // Only the owner's rsp_ready can complete the response.
    w_rsp_hs = (r_state == RESPOND) && |(rsp_ready & w_gidx_oh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req_hs) w_next = ISSUE;
      ISSUE:   w_next = RESPOND;
      RESPOND: if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_gidx      <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
    end else begin
      if (w_req_hs) begin
        r_op   <= req_op[int'(w_gidx)*OP_W +: OP_W];
        r_a    <= req_a[int'(w_gidx)*DATA_W +: DATA_W];
        r_b    <= req_b[int'(w_gidx)*DATA_W +: DATA_W];
        r_gidx <= w_gidx;
      end
      if (r_state == ISSUE) begin
        r_rsp_data  <= alu_result;
        r_rsp_valid <= w_gidx_oh;
      end
      if (w_rsp_hs) r_rsp_valid <= '0;
    end
  end

  assign alu_op_code = r_op;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign rsp_data    = r_rsp_data;
  assign rsp_valid   = r_rsp_valid;
  assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_alu_share_sequencer.sv
// Directed bench for alu_share_sequencer with a behavioural ALU and a
// response scoreboard filled at request time and drained at response time.
module tb_alu_share_sequencer;
  import alu_share_pkg::*;
  localparam int N = 4, DW = 8, OW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*OW-1:0] req_op;
  logic [N*DW-1:0] req_a, req_b;
  logic [DW-1:0]   rsp_data, alu_a, alu_b, alu_result;
  logic [OW-1:0]   alu_op_code;
  logic            busy;

  always #5 clk = ~clk;

  alu_share_sequencer #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .alu_op_code(alu_op_code),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .busy(busy)
  );

  always_comb begin
    case (alu_op_code)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  typedef struct packed {
    logic [N-1:0]  oh;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  logic [OW-1:0] t_op [N];
  logic [DW-1:0] t_a [N], t_b [N], t_res [N];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [OW-1:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [DW-1:0] res);
    t_op[i] = op; t_a[i] = a; t_b[i] = b; t_res[i] = res;
    req_op[i*OW +: OW] = op;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_valid[i]       = 1'b1;
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rvld"}, rsp_valid, e.oh);
      chk({tag, "_rdat"}, rsp_data, e.data);
    end
  endtask

  // Entered just after a negedge in IDLE with requests driven.
  task automatic serve(input int g, input logic [N-1:0] drop, input string tag);
    exp_t e;
    #1 chk({tag, "_grant"}, req_ready, 32'(1 << g));
    e.oh = N'(1 << g); e.data = t_res[g];
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    req_valid &= ~drop;
    chk({tag, "_op"}, alu_op_code, t_op[g]);
    chk({tag, "_a"}, alu_a, t_a[g]);
    chk({tag, "_b"}, alu_b, t_b[g]);
    chk({tag, "_rdy_iss"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 1);
    @(negedge clk);
    pop_chk(tag);
    @(negedge clk);
    chk({tag, "_idle"}, {rsp_valid, busy}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rvld"}, rsp_valid, 0);
    chk({tag, "_rdat"}, rsp_data, 0);
    chk({tag, "_alu"}, {alu_op_code, alu_a, alu_b}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, req_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    rsp_ready = '1;

    load(0, ALU_ADD, 8'h12, 8'h34, 8'h46);
    serve(0, 4'b0001, "add0");
    load(3, ALU_ADD, 8'hFF, 8'h01, 8'h00);
    serve(3, 4'b1000, "addwrap");

    // All four at once after requester 3 was last served: 0,1,2,3.
    load(0, ALU_OR,  8'hF0, 8'h3C, 8'hFC);
    load(1, ALU_AND, 8'hF0, 8'h3C, 8'h30);
    load(2, ALU_SUB, 8'h03, 8'h05, 8'hFE);
    load(3, ALU_ADD, 8'h7F, 8'h01, 8'h80);
    serve(0, 4'b0001, "rr0");
    serve(1, 4'b0010, "rr1");
    serve(2, 4'b0100, "rr2");
    serve(3, 4'b1000, "rr3");

    load(0, ALU_ADD, 8'h01, 8'h02, 8'h03);
    load(2, ALU_SUB, 8'h10, 8'h01, 8'h0F);
    serve(0, 4'b0000, "alt0a");
    serve(2, 4'b0000, "alt2a");
    serve(0, 4'b0000, "alt0b");
    serve(2, 4'b0101, "alt2b");

    // Backpressure on requester 1 while 0 and 3 wait.
    load(1, ALU_ADD, 8'h20, 8'h22, 8'h42);
    rsp_ready = 4'b1101;
    #1 chk("bp_grant", req_ready, 4'b0010);
    sb.push_back('{oh: 4'b0010, data: 8'h42});
    @(posedge clk); @(negedge clk);
    req_valid[1] = 1'b0;
    load(0, ALU_OR,  8'h0F, 8'hF0, 8'hFF);
    load(3, ALU_AND, 8'hAA, 8'h0F, 8'h0A);
    chk("bp_alu", {alu_op_code, alu_a, alu_b}, {ALU_ADD, 8'h20, 8'h22});
    @(negedge clk);
    pop_chk("bp_rsp");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_vld", rsp_valid, 4'b0010);
      chk("bp_hold_dat", rsp_data, 8'h42);
      chk("bp_hold_rdy", {req_ready, busy}, 5'b00001);
    end
    rsp_ready = '1;
    @(negedge clk);
    chk("bp_release", {rsp_valid, busy}, 0);
    serve(3, 4'b1000, "bp_next3");
    serve(0, 4'b0001, "bp_next0");

    // Requester 2 withdraws while 1 is in service.
    load(1, ALU_SUB, 8'h50, 8'h60, 8'hF0);
    load(2, ALU_ADD, 8'h01, 8'h01, 8'h02);
    serve(1, 4'b0110, "drop1");
    repeat (4) begin
      @(negedge clk);
      chk("drop_quiet", {rsp_valid, busy}, 0);
    end

    // Reset mid-ISSUE drops the operation and restarts priority at 0.
    load(2, ALU_ADD, 8'h11, 8'h22, 8'h33);
    #1 chk("rst_grant", req_ready, 4'b0100);
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    chk("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1 chk_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_quiet", {rsp_valid, busy}, 0);
    end
    load(0, ALU_AND, 8'hC3, 8'h5A, 8'h42);
    load(1, ALU_OR,  8'h01, 8'h02, 8'h03);
    load(2, ALU_SUB, 8'h00, 8'h01, 8'hFF);
    load(3, ALU_ADD, 8'h80, 8'h80, 8'h00);
    serve(0, 4'b1111, "rst_first");

    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
